// File: rtl/riscv_csr_port_arb.sv
// Shares the CSR state port between the execute-stage CSR path and the debug unit.
// Debug is granted when EX is idle or after a bounded wait, then performs a read and optional write.
module riscv_csr_port_arb #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [11:0]     ex_csr_reg,
    input  logic            ex_csr_we,
    input  logic [XLEN-1:0] ex_csr_wval,
    output logic [XLEN-1:0] ex_csr_rval,
    output logic            ex_stall_req,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [11:0]     dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [11:0]     st_csr_reg,
    output logic            st_csr_we,
    output logic [XLEN-1:0] st_csr_wval,
    input  logic [XLEN-1:0] st_csr_rval
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRD,
        S_DWR,
        S_DACK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          dbg_own;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Registered so the pulse lines up exactly with the DACK cycle.
            dbg_ack  <= (state_nxt == S_DACK);
            if (state == S_DRD)
                dbg_rdata <= st_csr_rval;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (dbg_req) begin
                    if (ex_valid) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = CW'(1);
                    end else begin
                        state_nxt = S_DRD;
                    end
                end
            end
            S_WAIT: begin
                if (!dbg_req) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else if (!ex_valid || wait_cnt == CW'(MAX_WAIT)) begin
                    state_nxt    = S_DRD;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            S_DRD:   state_nxt = dbg_we ? S_DWR : S_DACK;
            S_DWR:   state_nxt = S_DACK;
            S_DACK: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        dbg_own      = (state == S_DRD) || (state == S_DWR);
        ex_stall_req = dbg_own && !rst;
        st_csr_reg   = dbg_own ? dbg_addr : ex_csr_reg;
        st_csr_wval  = dbg_own ? dbg_wdata : ex_csr_wval;
        if (rst)
            st_csr_we = 1'b0;
        else if (state == S_DWR)
            st_csr_we = 1'b1;
        else if (state == S_DRD)
            st_csr_we = 1'b0;
        else
            st_csr_we = ex_csr_we && ex_valid;
    end

    assign ex_csr_rval = st_csr_rval;

endmodule
